// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS control FSM:
// state encoding, opcode values, ALU/mux encodings and the decoded control word.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Raw per-state control word; irwrite/pcwrite in FETCH still need MemReady qualification.
    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore decode of the FSM state into the datapath control word.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  cw
);

    always_comb begin
        cw = '0;
        case (state)
            S_FETCH: begin
                cw.alusrcb = SRCB_FOUR;
                cw.aluop   = ALUOP_ADD;
                cw.pcsrc   = PCSRC_ALU;
                cw.irwrite = 1'b1;
                cw.pcwrite = 1'b1;
            end
            S_DECODE: begin
                cw.alusrcb = SRCB_IMMSH;
                cw.aluop   = ALUOP_ADD;
            end
            S_MEMADR: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = SRCB_IMM;
                cw.aluop   = ALUOP_ADD;
            end
            S_MEMRD: cw.iord = 1'b1;
            S_MEMWB: begin
                cw.memtoreg = 1'b1;
                cw.regwrite = 1'b1;
            end
            S_MEMWR: begin
                cw.iord     = 1'b1;
                cw.memwrite = 1'b1;
            end
            S_EXECUTE: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = SRCB_REG;
                cw.aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                cw.regdst   = 1'b1;
                cw.regwrite = 1'b1;
            end
            S_BRANCH: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = SRCB_REG;
                cw.aluop   = ALUOP_SUB;
                cw.pcsrc   = PCSRC_ALUOUT;
                cw.branch  = 1'b1;
            end
            S_ADDIEXEC: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = SRCB_IMM;
                cw.aluop   = ALUOP_ADD;
            end
            S_ADDIWB: cw.regwrite = 1'b1;
            S_JUMP: begin
                cw.pcsrc   = PCSRC_JUMP;
                cw.pcwrite = 1'b1;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: state register, next-state logic,
// MemReady qualification, PCEn generation and retired-instruction counter.
module multicycle_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W      = 6,
    parameter int RET_CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OP_W-1:0]      Op,
    input  logic                 Zero,
    input  logic                 MemReady,
    output logic                 PCEn,
    output logic                 IorD,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic                 RegDst,
    output logic                 MemtoReg,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ALUOp,
    output logic [1:0]           PCSrc,
    output logic                 Illegal,
    output logic [RET_CNT_W-1:0] InstrRetired
);

    state_t               state, state_nxt;
    ctrl_t                cw;
    logic [RET_CNT_W-1:0] ret_cnt;
    logic                 retire;
    logic                 illegal_dec;
    logic                 pcwrite;

    mc_ctrl_outdec u_outdec (
        .state (state),
        .cw    (cw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ret_cnt <= '0;
        end else if (retire) begin
            ret_cnt <= ret_cnt + {{(RET_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_nxt   = state;
        retire      = 1'b0;
        illegal_dec = 1'b0;
        case (state)
            S_FETCH:  if (MemReady) state_nxt = S_DECODE;
            S_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXECUTE;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_ADDI:      state_nxt = S_ADDIEXEC;
                    OP_J:         state_nxt = S_JUMP;
                    default: begin
                        state_nxt   = S_FETCH;
                        illegal_dec = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_nxt = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    if (MemReady) state_nxt = S_MEMWB;
            S_MEMWR: begin
                if (MemReady) begin
                    state_nxt = S_FETCH;
                    retire    = 1'b1;
                end
            end
            S_EXECUTE:  state_nxt = S_ALUWB;
            S_ADDIEXEC: state_nxt = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
                state_nxt = S_FETCH;
                retire    = 1'b1;
            end
            default:    state_nxt = S_FETCH;
        endcase
    end

    // The FETCH write enables only fire on the cycle the memory returns the instruction.
    assign pcwrite = cw.pcwrite & (MemReady | (state != S_FETCH));

    always_comb begin
        PCEn         = 1'b0;
        IorD         = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegDst       = 1'b0;
        MemtoReg     = 1'b0;
        RegWrite     = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUOp        = 2'b00;
        PCSrc        = 2'b00;
        Illegal      = 1'b0;
        InstrRetired = '0;
        if (!rst) begin
            PCEn         = pcwrite | (cw.branch & Zero);
            IorD         = cw.iord;
            MemWrite     = cw.memwrite;
            IRWrite      = cw.irwrite & MemReady;
            RegDst       = cw.regdst;
            MemtoReg     = cw.memtoreg;
            RegWrite     = cw.regwrite;
            ALUSrcA      = cw.alusrca;
            ALUSrcB      = cw.alusrcb;
            ALUOp        = cw.aluop;
            PCSrc        = cw.pcsrc;
            Illegal      = illegal_dec;
            InstrRetired = ret_cnt;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes expected per-cycle control words,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic        pcen;
        logic        iord;
        logic        memwrite;
        logic        irwrite;
        logic        regdst;
        logic        memtoreg;
        logic        regwrite;
        logic        alusrca;
        logic [1:0]  alusrcb;
        logic [1:0]  aluop;
        logic [1:0]  pcsrc;
        logic        illegal;
        logic [31:0] retired;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  Op = '0;
    logic        Zero = 1'b0;
    logic        MemReady = 1'b0;
    logic        PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Illegal;
    logic [1:0]  ALUSrcB, ALUOp, PCSrc;
    logic [31:0] InstrRetired;

    obs_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_ret    = 0;
    int    cyc_no   = 0;

    multicycle_ctrl #(.OP_W(6), .RET_CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .Op           (Op),
        .Zero         (Zero),
        .MemReady     (MemReady),
        .PCEn         (PCEn),
        .IorD         (IorD),
        .MemWrite     (MemWrite),
        .IRWrite      (IRWrite),
        .RegDst       (RegDst),
        .MemtoReg     (MemtoReg),
        .RegWrite     (RegWrite),
        .ALUSrcA      (ALUSrcA),
        .ALUSrcB      (ALUSrcB),
        .ALUOp        (ALUOp),
        .PCSrc        (PCSrc),
        .Illegal      (Illegal),
        .InstrRetired (InstrRetired)
    );

    always #5 clk = ~clk;

    // Expected outputs of one phase of an instruction, straight from the phase descriptions.
    function automatic obs_t phase_out(string p, bit mr, bit z, bit ill, int ret);
        obs_t o;
        o = '0;
        o.retired = 32'(ret);
        case (p)
            "FETCH":    begin o.alusrcb = 2'b01; o.irwrite = mr; o.pcen = mr; end
            "DECODE":   begin o.alusrcb = 2'b11; o.illegal = ill; end
            "MEMADR":   begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            "MEMRD":    o.iord = 1'b1;
            "MEMWB":    begin o.memtoreg = 1'b1; o.regwrite = 1'b1; end
            "MEMWR":    begin o.iord = 1'b1; o.memwrite = 1'b1; end
            "EXECUTE":  begin o.alusrca = 1'b1; o.aluop = 2'b10; end
            "ALUWB":    begin o.regdst = 1'b1; o.regwrite = 1'b1; end
            "BRANCH":   begin o.alusrca = 1'b1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.pcen = z; end
            "ADDIEXEC": begin o.alusrca = 1'b1; o.alusrcb = 2'b10; end
            "ADDIWB":   o.regwrite = 1'b1;
            "JUMP":     begin o.pcsrc = 2'b10; o.pcen = 1'b1; end
            default:    o = '0;
        endcase
        return o;
    endfunction

    function automatic bit is_legal(logic [5:0] op);
        return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    function automatic logic [5:0] rnd_op();
        return 6'($urandom_range(0, 63));
    endfunction

    task automatic cyc(input logic [5:0] op_v, input bit z_v, input bit mr_v,
                       input string p, input bit ill);
        rst      = 1'b0;
        Op       = op_v;
        Zero     = z_v;
        MemReady = mr_v;
        exp_q.push_back(phase_out(p, mr_v, z_v, ill, n_ret));
        tag_q.push_back($sformatf("%s@%0d", p, cyc_no));
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic rst_cyc();
        rst      = 1'b1;
        Op       = rnd_op();
        Zero     = 1'($urandom_range(0, 1));
        MemReady = 1'($urandom_range(0, 1));
        exp_q.push_back('0);
        tag_q.push_back($sformatf("RESET@%0d", cyc_no));
        cyc_no++;
        n_ret = 0;
        @(posedge clk);
        #1;
    endtask

    // Fetch with stalls, decode, then the opcode-specific phases; retire after the last phase.
    task automatic run_instr(input logic [5:0] op, input int fstall, input int mstall, input bit z);
        bit zr;
        repeat (fstall) cyc(rnd_op(), 1'($urandom_range(0, 1)), 1'b0, "FETCH", 1'b0);
        cyc(rnd_op(), 1'($urandom_range(0, 1)), 1'b1, "FETCH", 1'b0);
        zr = 1'($urandom_range(0, 1));
        cyc(op, zr, 1'($urandom_range(0, 1)), "DECODE", !is_legal(op));
        if (!is_legal(op)) return;
        case (op)
            6'b100011: begin
                cyc(op, 1'b0, 1'($urandom_range(0, 1)), "MEMADR", 1'b0);
                repeat (mstall) cyc(op, 1'b0, 1'b0, "MEMRD", 1'b0);
                cyc(op, 1'b0, 1'b1, "MEMRD", 1'b0);
                cyc(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "MEMWB", 1'b0);
            end
            6'b101011: begin
                cyc(op, 1'b0, 1'($urandom_range(0, 1)), "MEMADR", 1'b0);
                repeat (mstall) cyc(op, 1'($urandom_range(0, 1)), 1'b0, "MEMWR", 1'b0);
                cyc(op, 1'b0, 1'b1, "MEMWR", 1'b0);
            end
            6'b000000: begin
                cyc(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "EXECUTE", 1'b0);
                cyc(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "ALUWB", 1'b0);
            end
            6'b000100: cyc(op, z, 1'($urandom_range(0, 1)), "BRANCH", 1'b0);
            6'b001000: begin
                cyc(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "ADDIEXEC", 1'b0);
                cyc(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "ADDIWB", 1'b0);
            end
            default:   cyc(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "JUMP", 1'b0);
        endcase
        n_ret++;
    endtask

    always @(negedge clk) begin
        obs_t  act, exp_v;
        string tag;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            tag   = tag_q.pop_front();
            act   = {PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                     ALUSrcB, ALUOp, PCSrc, Illegal, InstrRetired};
            n_checks++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL %s: got %h required %h", tag, act, exp_v);
            end
        end
    end

    initial begin
        logic [5:0] legal_ops [6];
        legal_ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

        @(posedge clk);
        #1;
        rst_cyc();
        rst_cyc();

        run_instr(6'b100011, 0, 0, 1'b0);              // lw, no stalls
        run_instr(6'b101011, 0, 3, 1'b0);              // sw, MEMWR stalled 3 cycles
        run_instr(6'b000100, 0, 0, 1'b1);              // beq taken
        run_instr(6'b000100, 0, 0, 1'b0);              // beq not taken
        run_instr(6'b000000, 0, 0, 1'b0);              // R-type
        run_instr(6'b000010, 0, 0, 1'b0);              // j
        run_instr(6'b111111, 0, 0, 1'b0);              // illegal
        run_instr(6'b001000, 2, 0, 1'b0);              // addi after fetch stalls
        run_instr(6'b100011, 1, 2, 1'b0);              // lw with stalls

        // Reset in the middle of an R-type EXECUTE.
        cyc(rnd_op(), 1'b0, 1'b1, "FETCH", 1'b0);
        cyc(6'b000000, 1'b0, 1'b0, "DECODE", 1'b0);
        cyc(6'b000000, 1'b0, 1'b0, "EXECUTE", 1'b0);
        rst_cyc();
        rst_cyc();
        run_instr(6'b101011, 0, 0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            int k;
            logic [5:0] op;
            k  = $urandom_range(0, 6);
            op = (k == 6) ? rnd_op() : legal_ops[k];
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 99) == 0) begin
                rst_cyc();
                rst_cyc();
            end
        end

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
